axi_sts_read_arbiter: RTL and testbench

- Two-master, one-slave AXI4-Lite read-channel arbiter.
- Lets two requesters share one status-register slave port, e.g. the PS GP port and an FPGA-side monitor sequencer.
- Round-robin grant, one transaction in flight at a time.
- A response timeout with SLVERR protects requesters from a hung slave.

---
 rtl/axi_sts_read_arbiter_if.sv | 24 ++
 rtl/axi_sts_read_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_sts_read_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sts_read_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by both requester ports and the slave port.
// The master modport is the side that issues addresses; the slave modport answers them.
interface axi_sts_read_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_sts_read_arbiter.sv
// Two-requester AXI4-Lite read arbiter: round-robin grant, one read in flight, and a
// response timeout that answers SLVERR and then swallows the slave's late beat.
module axi_sts_read_arbiter #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH = 16,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axi_sts_read_arbiter_if.slave   s0_axi,
    axi_sts_read_arbiter_if.slave   s1_axi,
    axi_sts_read_arbiter_if.master  m_axi
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [AXI_DATA_WIDTH-1:0] ERR_WORD = AXI_DATA_WIDTH'(ERR_DATA);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        FLUSH
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      last_grant;
    logic                      grant;
    logic                      flush_pending;
    logic [CNT_W-1:0]          count;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    logic sel;
    logic ar_fire;
    logic expire;
    logic up_fire;
    logic s0_arready;
    logic s1_arready;
    logic s0_rvalid;
    logic s1_rvalid;
    logic m_arvalid;
    logic m_rready;

    assign ar_fire = (state == IDLE) && (s0_axi.arvalid || s1_axi.arvalid);
    // A slave beat arriving on the last allowed cycle wins over the timeout.
    assign expire  = (TIMEOUT_CYCLES != 0) && (state == DATA) &&
                     (count == CNT_LAST) && !m_axi.rvalid;
    assign up_fire = (state == RESP) && (grant ? s1_axi.rready : s0_axi.rready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_next = state;
        sel        = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;

        if (s0_axi.arvalid && s1_axi.arvalid) sel = ~last_grant;
        else if (s1_axi.arvalid)              sel = 1'b1;

        case (state)
            IDLE: begin
                s0_arready = s0_axi.arvalid && !sel;
                s1_arready = s1_axi.arvalid && sel;
                if (ar_fire) state_next = ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_axi.arready) state_next = DATA;
            end
            DATA: begin
                m_rready = 1'b1;
                if (m_axi.rvalid || expire) state_next = RESP;
            end
            RESP: begin
                s0_rvalid = !grant;
                s1_rvalid = grant;
                if (up_fire) state_next = flush_pending ? FLUSH : IDLE;
            end
            FLUSH: begin
                m_rready = 1'b1;
                if (m_axi.rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: sequential state uses non-blocking assignments only.
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            flush_pending <= 1'b0;
            count         <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            rresp_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        addr_q     <= sel ? s1_axi.araddr : s0_axi.araddr;
                        grant      <= sel;
                        last_grant <= sel;
                    end
                end
                ADDR: begin
                    if (m_axi.arready) count <= '0;
                end
                DATA: begin
                    count <= count + 1'b1;
                    if (m_axi.rvalid) begin
                        rdata_q       <= m_axi.rdata;
                        rresp_q       <= m_axi.rresp;
                        flush_pending <= 1'b0;
                    end else if (expire) begin
                        rdata_q       <= ERR_WORD;
                        rresp_q       <= RESP_SLVERR;
                        flush_pending <= 1'b1;
                    end
                end
                RESP: begin
                    if (up_fire) flush_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Data is only presented to the granted requester while its response is pending.
    assign s0_axi.arready = s0_arready;
    assign s1_axi.arready = s1_arready;
    assign s0_axi.rvalid  = s0_rvalid;
    assign s1_axi.rvalid  = s1_rvalid;
    assign s0_axi.rdata   = s0_rvalid ? rdata_q : '0;
    assign s1_axi.rdata   = s1_rvalid ? rdata_q : '0;
    assign s0_axi.rresp   = s0_rvalid ? rresp_q : 2'b00;
    assign s1_axi.rresp   = s1_rvalid ? rresp_q : 2'b00;

    assign m_axi.araddr   = addr_q;
    assign m_axi.arvalid  = m_arvalid;
    assign m_axi.rready   = m_rready;
endmodule

// File: tb/tb_axi_sts_read_arbiter.sv
// Directed bench for axi_sts_read_arbiter: single read, round-robin ties, backpressure,
// timeout with late-beat flush, expiry race and asynchronous reset mid-transaction.
module tb_axi_sts_read_arbiter;
    logic aclk;
    logic aresetn;
    int   compared;
    int   mismatched;

    axi_sts_read_arbiter_if #(.ADDR_W(16), .DATA_W(32)) s0 ();
    axi_sts_read_arbiter_if #(.ADDR_W(16), .DATA_W(32)) s1 ();
    axi_sts_read_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m ();

    axi_sts_read_arbiter #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s0_axi (s0),
        .s1_axi (s1),
        .m_axi  (m)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Entered one cycle after the requester handshake (arbiter in ADDR); leaves it in IDLE.
    task automatic serve(input bit who, input logic [15:0] addr, input logic [31:0] data,
                         input int hold);
        chk("arvalid_latency", m.arvalid, 1);
        chk("araddr", m.araddr, addr);
        m.arready = 1'b1;
        tick();
        m.arready = 1'b0;
        #1;
        chk("data_rready", m.rready, 1);
        chk("data_arvalid_low", m.arvalid, 0);
        m.rvalid = 1'b1;
        m.rdata  = data;
        m.rresp  = 2'b00;
        tick();
        m.rvalid = 1'b0;
        m.rdata  = '0;
        #1;
        chk("rvalid_latency", who ? s1.rvalid : s0.rvalid, 1);
        chk("rdata", who ? s1.rdata : s0.rdata, data);
        chk("rresp", who ? s1.rresp : s0.rresp, 0);
        chk("other_rvalid", who ? s0.rvalid : s1.rvalid, 0);
        chk("other_rdata", who ? s0.rdata : s1.rdata, 0);
        if (hold > 0) begin
            if (who) s1.rready = 1'b0;
            else     s0.rready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("bp_rvalid", who ? s1.rvalid : s0.rvalid, 1);
                chk("bp_rdata", who ? s1.rdata : s0.rdata, data);
                chk("bp_arvalid", m.arvalid, 0);
                chk("bp_no_grant", {31'd0, s0.arready | s1.arready}, 0);
            end
            if (who) s1.rready = 1'b1;
            else     s0.rready = 1'b1;
        end
        tick();
        chk("rvalid_clear", who ? s1.rvalid : s0.rvalid, 0);
    endtask

    initial begin
        logic [15:0] win_addr;
        bit          w;

        compared   = 0;
        mismatched = 0;
        aresetn    = 1'b0;
        s0.araddr  = '0; s0.arvalid = 1'b0; s0.rready = 1'b1;
        s1.araddr  = '0; s1.arvalid = 1'b0; s1.rready = 1'b1;
        m.arready  = 1'b0; m.rdata = '0; m.rresp = 2'b00; m.rvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_s0_arready", s0.arready, 0);
        chk("rst_s1_arready", s1.arready, 0);
        chk("rst_s0_rvalid", s0.rvalid, 0);
        chk("rst_s1_rvalid", s1.rvalid, 0);
        chk("rst_s0_rdata", s0.rdata, 0);
        chk("rst_s0_rresp", s0.rresp, 0);
        chk("rst_m_arvalid", m.arvalid, 0);
        chk("rst_m_rready", m.rready, 0);
        chk("rst_m_araddr", m.araddr, 0);
        aresetn = 1'b1;
        tick();

        // Contention: both request every round, grants must alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            s0.araddr  = 16'(8 * k);
            s1.araddr  = 16'(8 * k + 4);
            s0.arvalid = 1'b1;
            s1.arvalid = 1'b1;
            #1;
            w = k[0];
            win_addr = w ? s1.araddr : s0.araddr;
            chk("tie_s0_arready", s0.arready, {31'd0, !w});
            chk("tie_s1_arready", s1.arready, {31'd0, w});
            chk("tie_m_arvalid", m.arvalid, 0);
            tick();
            chk("loser_arready_busy", w ? s0.arready : s1.arready, 0);
            serve(w, win_addr, 32'h0000_00A0 + 32'(win_addr), 0);
        end
        s0.arvalid = 1'b0;
        s1.arvalid = 1'b0;

        // Backpressure on s1 while s0 waits
        s1.araddr  = 16'h0020;
        s1.arvalid = 1'b1;
        #1;
        chk("bp_s1_arready", s1.arready, 1);
        tick();
        s1.arvalid = 1'b0;
        s0.araddr  = 16'h0030;
        s0.arvalid = 1'b1;
        serve(1'b1, 16'h0020, 32'h0000_0077, 5);
        chk("grant_after_bp", s0.arready, 1);
        tick();
        s0.arvalid = 1'b0;
        serve(1'b0, 16'h0030, 32'h0000_0088, 0);

        // Single read from s0
        s0.araddr  = 16'h0008;
        s0.arvalid = 1'b1;
        #1;
        chk("single_s0_arready", s0.arready, 1);
        chk("single_s1_arready", s1.arready, 0);
        chk("single_m_arvalid_pre", m.arvalid, 0);
        tick();
        s0.arvalid = 1'b0;
        serve(1'b0, 16'h0008, 32'h1234_5678, 0);

        // Timeout: slave never answers, SLVERR after exactly 8 DATA cycles
        s0.araddr  = 16'h0040;
        s0.arvalid = 1'b1;
        #1;
        tick();
        s0.arvalid = 1'b0;
        chk("to_arvalid", m.arvalid, 1);
        m.arready = 1'b1;
        tick();
        m.arready = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_rvalid", s0.rvalid, 0);
            chk("to_wait_rready", m.rready, 1);
            tick();
        end
        chk("to_rvalid", s0.rvalid, 1);
        chk("to_rdata", s0.rdata, 32'hDEADBEEF);
        chk("to_rresp", s0.rresp, 2);
        chk("to_resp_rready", m.rready, 0);
        s1.araddr  = 16'h0050;
        s1.arvalid = 1'b1;
        #1;
        chk("to_resp_no_grant", s1.arready, 0);
        tick();
        chk("flush_rready", m.rready, 1);
        chk("flush_no_grant", s1.arready, 0);
        chk("flush_s0_rvalid", s0.rvalid, 0);
        tick();
        chk("flush_hold_no_grant", s1.arready, 0);
        m.rvalid = 1'b1;
        m.rdata  = 32'h0000_0055;
        tick();
        m.rvalid = 1'b0;
        m.rdata  = '0;
        #1;
        chk("post_flush_grant", s1.arready, 1);
        chk("post_flush_rready", m.rready, 0);
        chk("stray_beat_dropped", s1.rvalid, 0);
        tick();
        s1.arvalid = 1'b0;
        serve(1'b1, 16'h0050, 32'h5A5A_0050, 0);

        // Expiry race: slave beat on the final timeout cycle is a normal response
        s0.araddr  = 16'h0060;
        s0.arvalid = 1'b1;
        #1;
        tick();
        s0.arvalid = 1'b0;
        m.arready  = 1'b1;
        tick();
        m.arready  = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        m.rvalid = 1'b1;
        m.rdata  = 32'h0000_0066;
        m.rresp  = 2'b00;
        tick();
        m.rvalid = 1'b0;
        m.rdata  = '0;
        #1;
        chk("race_rvalid", s0.rvalid, 1);
        chk("race_rdata", s0.rdata, 32'h0000_0066);
        chk("race_rresp", s0.rresp, 0);
        tick();
        chk("race_no_flush", m.rready, 0);
        chk("race_rvalid_clear", s0.rvalid, 0);
        s1.arvalid = 1'b1;
        #1;
        chk("race_idle_grant", s1.arready, 1);
        s1.arvalid = 1'b0;

        // Asynchronous reset in DATA, then s0 must win the first tie again
        s0.araddr  = 16'h0070;
        s0.arvalid = 1'b1;
        #1;
        tick();
        s0.arvalid = 1'b0;
        m.arready  = 1'b1;
        tick();
        m.arready  = 1'b0;
        #1;
        chk("pre_rst_rready", m.rready, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_m_rready", m.rready, 0);
        chk("arst_m_arvalid", m.arvalid, 0);
        chk("arst_m_araddr", m.araddr, 0);
        chk("arst_s0_rvalid", s0.rvalid, 0);
        chk("arst_s0_rdata", s0.rdata, 0);
        chk("arst_s1_rvalid", s1.rvalid, 0);
        tick();
        tick();
        aresetn    = 1'b1;
        s0.arvalid = 1'b1;
        s1.arvalid = 1'b1;
        #1;
        chk("post_rst_tie_s0", s0.arready, 1);
        chk("post_rst_tie_s1", s1.arready, 0);
        s0.arvalid = 1'b0;
        s1.arvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
